multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel bus timer, the successor to the single-channel 1 ms timer on the processor bus. It provides NUM_CH independent CNT_W-bit tick counters sharing one prescaler. Each channel has a programmable period, periodic or one-shot mode, sticky status flags and an interrupt enable. All channel events merge onto the single timer interrupt line, using the existing RAISE/ACK handshake.

## Interface
- BASE_ADDR, 8'hE0: first byte of the register window; 8 addresses per channel, channel c at BASE_ADDR+8c.
- NUM_CH, 2: channel count, 1..4.
- CNT_W, 16: counter/period width, 8 or 16.
- PRESCALE, 50000: CLK cycles per tick, ≥2.
- INIT_PERIOD, 100: reset value of every channel's PERIOD.
- INIT_CTRL0, 3'b101: reset CTRL of channel 0; other channels reset to 0.
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- BUS_DATA  inout  8  shared data bus; driven only during a read slot, else 8'hZZ.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  write strobe; a write occurs on any cycle with BUS_WE=1 and a matching address.
- BUS_INTERRUPT_RAISE  out  1  timer interrupt request; reset 0.
- BUS_INTERRUPT_ACK  in  1  processor acknowledge, one cycle.

## Operation
- Per-channel offsets:
  - +0 CNT_LO (R).
  - +1 CNT_HI (R, shadow).
  - +2 PER_LO (R/W, commit).
  - +3 PER_HI (R/W, staging).
  - +4 CTRL (R/W: bit0 EN, bit1 ONESHOT, bit2 IE).
  - +5 STATUS (R, W1C: bit0 PEND, bit1 OVR).
  - +6 CLEAR (W: CNT←0).
  - +7 reads 0.
- Unused bits read 0. Addresses beyond NUM_CH channels are ignored.
- Prescaler: PS counts 0..PRESCALE-1 and wraps; tick=1 when PS==PRESCALE-1.
- Channel update on a tick with EN=1:
  - If PERIOD≠0 and CNT==PERIOD-1: event. CNT←0. If ONESHOT, EN←0.
  - Otherwise CNT←CNT+1, wrapping modulo 2^CNT_W.
  - PERIOD=0: no events; the counter free-runs.
- EN=0 freezes CNT. Setting EN does not clear CNT.
- Event: PEND←1. If PEND was already 1, OVR←1 as well.
- IRQ flag: set when any channel has an event with IE=1; cleared by BUS_INTERRUPT_ACK. BUS_INTERRUPT_RAISE = IRQ flag.
- ACK does not touch STATUS; the ISR reads STATUS and clears it via W1C.
- 16-bit reads:
  - A read slot on CNT_LO copies CNT[15:8] into the shadow in the same cycle; CNT_HI returns the shadow.
  - PER_HI writes go to staging. A PER_LO write commits PERIOD={staging, data}.
  - PER_HI reads return PERIOD[15:8].
- CNT_W=8: HI addresses read 0, writes ignored, and PER_LO commits directly.

## Timing
- Read slot: a cycle with a matching address and BUS_WE=0. BUS_DATA drives the selected value in the following cycle only, sampled at that slot's edge; otherwise Z.
- Writes take effect at the edge ending the write cycle.
- Event → PEND, CNT reload and IRQ flag all update at the edge ending the tick cycle. RAISE is high from the next cycle.
- Priorities, same cycle:
  - Event vs ACK: event wins, IRQ stays 1.
  - Event vs W1C on PEND: PEND stays 1. OVR is set only if PEND was 1 before the cycle.
  - CLEAR vs tick: CLEAR wins, CNT=0, no event.
  - CTRL write vs tick: the tick uses the old CTRL.
  - PER commit vs tick: the tick compares against the old PERIOD.
- Reset (any time, asynchronous):
  - RAISE=0, BUS_DATA=Z, PS=0, all CNT=0, shadow/staging=0, STATUS=0, PERIOD=INIT_PERIOD.
  - CTRL0=INIT_CTRL0, other CTRLs=0.
  - No event is generated on reset release.

## Configuration
- MULTI_TIMER_ONESHOT_EN defined: CTRL.ONESHOT is writable and functional as above.
- Undefined: ONESHOT is tied 0 and reads 0; all channels are periodic only.

## Test plan
- PRESCALE=4, reset release, ch0 defaults (EN, IE, PERIOD=100): the first event fires on the 100th tick (edge at cycle 400). RAISE rises; ACK drops it; STATUS0 reads 8'h01.
- Ch1 PERIOD=3, ONESHOT=1, EN=1: exactly one event after 3 ticks, then EN reads 0 and CNT holds 0 for 20 further ticks.
- Ch0 PERIOD=2, IE=1, PEND never cleared for 3 events: STATUS=8'h03. W1C 8'h03 → 8'h00.
- CNT_W=16, PERIOD=0, EN=1: after 65 536 ticks CNT wraps to 0 with no event. Read CNT_LO then CNT_HI at CNT=16'h01FF, with a tick between the two reads: the bytes read are FF then 01.
- ACK asserted in the same cycle as a ch0 event: RAISE stays 1. CLEAR written on a tick cycle: CNT reads 0 and no event occurs.
- Assert RESET_N low mid-period with RAISE=1: RAISE goes 0 immediately with no clock edge, and all registers return to their reset values.

Source files
------------

// File: rtl/multi_timer_if.sv
// Processor-side address/strobe and interrupt RAISE/ACK bundle for multi_timer.
// The shared 8-bit data bus stays a plain inout port on the timer.
interface multi_timer_if;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic       irq_raise;
    logic       irq_ack;

    modport master (output bus_addr, output bus_we, input irq_raise, output irq_ack);
    modport slave  (input bus_addr, input bus_we, output irq_raise, input irq_ack);
endinterface

// File: rtl/multi_timer.sv
// NUM_CH bus-mapped tick counters sharing one prescaler, merged onto one RAISE/ACK interrupt.
// Define MULTI_TIMER_ONESHOT_EN to make CTRL.ONESHOT writable; otherwise channels are periodic only.
module multi_timer #(
    parameter logic [7:0] BASE_ADDR   = 8'hE0,
    parameter int         NUM_CH      = 2,
    parameter int         CNT_W       = 16,
    parameter int         PRESCALE    = 50000,
    parameter int         INIT_PERIOD = 100,
    parameter logic [2:0] INIT_CTRL0  = 3'b101
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    multi_timer_if.slave bus,
    inout  wire  [7:0]   bus_data_io
);
`ifdef MULTI_TIMER_ONESHOT_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b101;
`endif
    localparam int              PS_W     = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [7:0]      WIN_SIZE = 8'(8 * NUM_CH);

    logic [7:0] wdata;
    logic [7:0] off;
    logic       hit;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] ch_sel;
    logic [2:0] reg_sel;
    logic       tick;

    // Addresses below BASE_ADDR wrap to large offsets and fall outside the window.
    assign wdata   = bus_data_io;
    assign off     = bus.bus_addr - BASE_ADDR;
    assign hit     = (off < WIN_SIZE);
    assign ch_sel  = off[4:3];
    assign reg_sel = off[2:0];
    assign wr_en   = hit & bus.bus_we;
    assign rd_en   = hit & ~bus.bus_we;

    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;

    assign tick = (ps_q == PS_LAST);
    assign ps_d = tick ? '0 : ps_q + PS_W'(1);

    logic [NUM_CH-1:0]      irq_evt;
    logic [NUM_CH-1:0][7:0] rd_val;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] per_q, per_d;
        logic [15:0]      cnt_w16;
        logic [15:0]      per_w16;
        logic [2:0]       ctrl_q, ctrl_d;
        logic             pend_q, pend_d;
        logic             ovr_q, ovr_d;
        logic [7:0]       shadow_q, shadow_d;
        logic [7:0]       stage_q, stage_d;
        logic [7:0]       rd_ch;
        logic             sel, wr_ch, clr, w1c_pend, w1c_ovr, evt;

        assign sel      = (ch_sel == 2'(gi));
        assign wr_ch    = wr_en & sel;
        assign clr      = wr_ch & (reg_sel == 3'd6);
        assign w1c_pend = wr_ch & (reg_sel == 3'd5) & wdata[0];
        assign w1c_ovr  = wr_ch & (reg_sel == 3'd5) & wdata[1];
        assign cnt_w16  = 16'(cnt_q);
        assign per_w16  = 16'(per_q);

        // Tick decisions use pre-write CTRL/PERIOD; a same-cycle CLEAR suppresses the event.
        assign evt = tick & ctrl_q[0] & ~clr & (per_q != '0) & (cnt_q == per_q - CNT_W'(1));

        always_comb begin
            cnt_d    = cnt_q;
            per_d    = per_q;
            ctrl_d   = ctrl_q;
            stage_d  = stage_q;
            shadow_d = shadow_q;
            if (clr) begin
                cnt_d = '0;
            end else if (evt) begin
                cnt_d = '0;
                if (ctrl_q[1]) ctrl_d[0] = 1'b0;
            end else if (tick && ctrl_q[0]) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (wr_ch) begin
                case (reg_sel)
                    3'd2:    per_d = CNT_W'({stage_q, wdata});
                    3'd3:    if (CNT_W == 16) stage_d = wdata;
                    3'd4:    ctrl_d = wdata[2:0] & CTRL_MASK;
                    default: ;
                endcase
            end
            if (rd_en && sel && (reg_sel == 3'd0)) shadow_d = cnt_w16[15:8];
            pend_d = evt | (pend_q & ~w1c_pend);
            ovr_d  = (evt & pend_q) | (ovr_q & ~w1c_ovr);
        end

        always_comb begin
            rd_ch = 8'h00;
            case (reg_sel)
                3'd0:    rd_ch = cnt_w16[7:0];
                3'd1:    rd_ch = shadow_q;
                3'd2:    rd_ch = per_w16[7:0];
                3'd3:    rd_ch = per_w16[15:8];
                3'd4:    rd_ch = {5'b00000, ctrl_q};
                3'd5:    rd_ch = {6'b000000, ovr_q, pend_q};
                default: rd_ch = 8'h00;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q    <= '0;
                per_q    <= CNT_W'(INIT_PERIOD);
                ctrl_q   <= (gi == 0) ? (INIT_CTRL0 & CTRL_MASK) : 3'b000;
                pend_q   <= 1'b0;
                ovr_q    <= 1'b0;
                shadow_q <= 8'h00;
                stage_q  <= 8'h00;
            end else begin
                cnt_q    <= cnt_d;
                per_q    <= per_d;
                ctrl_q   <= ctrl_d;
                pend_q   <= pend_d;
                ovr_q    <= ovr_d;
                shadow_q <= shadow_d;
                stage_q  <= stage_d;
            end
        end

        assign irq_evt[gi] = evt & ctrl_q[2];
        assign rd_val[gi]  = rd_ch;
    end

    logic       irq_q, irq_d;
    logic       oe_q;
    logic [7:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 2'(c)) rdata_d = rd_val[c];
        end
    end

    // A same-cycle event beats ACK.
    assign irq_d = (|irq_evt) | (irq_q & ~bus.irq_ack);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ps_q    <= '0;
            irq_q   <= 1'b0;
            oe_q    <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            ps_q    <= ps_d;
            irq_q   <= irq_d;
            oe_q    <= rd_en;
            rdata_q <= rdata_d;
        end
    end

    assign bus.irq_raise = irq_q;
    assign bus_data_io   = oe_q ? rdata_q : 8'hzz;
endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: a tick-level reference model predicts reads and RAISE.
module tb_multi_timer;
    localparam int PS   = 4;
    localparam int NCH  = 2;
    localparam int BASE = 224;
`ifdef MULTI_TIMER_ONESHOT_EN
    localparam bit OS_OK = 1'b1;
`else
    localparam bit OS_OK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_wdata = 8'h00;
    wire  [7:0] bus_data;

    assign bus_data = tb_drv ? tb_wdata : 8'hzz;

    multi_timer_if bus_if ();

    multi_timer #(
        .BASE_ADDR(8'hE0), .NUM_CH(NCH), .CNT_W(16), .PRESCALE(PS),
        .INIT_PERIOD(100), .INIT_CTRL0(3'b101)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_if), .bus_data_io(bus_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit mon_on = 1'b0;

    typedef struct packed { logic [7:0] addr; logic [7:0] exp; } sb_t;
    sb_t sb_q[$];

    // Reference model state
    int m_cnt[NCH], m_per[NCH], m_shadow[NCH], m_stage[NCH];
    bit m_en[NCH], m_os[NCH], m_ie[NCH], m_pend[NCH], m_ovr[NCH];
    int m_ps;
    bit m_irq;
    bit m_out_valid;

    function automatic logic [7:0] m_read(input int c, input int r);
        case (r)
            0:       return 8'(m_cnt[c] % 256);
            1:       return 8'(m_shadow[c]);
            2:       return 8'(m_per[c] % 256);
            3:       return 8'(m_per[c] / 256);
            4:       return {5'b0, m_ie[c], m_os[c], m_en[c]};
            5:       return {6'b0, m_ovr[c], m_pend[c]};
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit ev_now(input int c);
        return m_en[c] && (m_ps == PS - 1) && (m_per[c] != 0) && (m_cnt[c] == m_per[c] - 1);
    endfunction

    function automatic bit in_win(input logic [7:0] a);
        return (int'(a) >= BASE) && (int'(a) < BASE + 8 * NCH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int a, ch, r, wd;
        bit hit, we, tick, irq_set, wr, clr, evt, pend0, ie0, os0, en0;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 0; m_per[c] = 100; m_shadow[c] = 0; m_stage[c] = 0;
                m_en[c] = (c == 0); m_ie[c] = (c == 0); m_os[c] = 1'b0;
                m_pend[c] = 1'b0; m_ovr[c] = 1'b0;
            end
            m_ps = 0; m_irq = 1'b0; m_out_valid = 1'b0;
            sb_q.delete();
        end else begin
            a   = int'(bus_if.bus_addr);
            we  = bus_if.bus_we;
            wd  = int'(tb_wdata);
            hit = in_win(bus_if.bus_addr);
            ch  = (a - BASE) / 8;
            r   = (a - BASE) % 8;
            m_out_valid = 1'b0;
            if (hit && !we) begin
                sb_q.push_back('{addr: bus_if.bus_addr, exp: m_read(ch, r)});
                m_out_valid = 1'b1;
                if (r == 0) m_shadow[ch] = m_cnt[ch] / 256;
            end
            tick = (m_ps == PS - 1);
            m_ps = (m_ps + 1) % PS;
            irq_set = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                wr = hit && we && (ch == c);
                clr = wr && (r == 6);
                en0 = m_en[c]; os0 = m_os[c]; ie0 = m_ie[c]; pend0 = m_pend[c];
                evt = 1'b0;
                if (tick && en0 && !clr) begin
                    if (m_per[c] != 0 && m_cnt[c] == m_per[c] - 1) begin
                        evt = 1'b1;
                        m_cnt[c] = 0;
                        if (os0) m_en[c] = 1'b0;
                    end else begin
                        m_cnt[c] = (m_cnt[c] + 1) % 65536;
                    end
                end
                if (clr) m_cnt[c] = 0;
                if (wr && r == 2) m_per[c] = m_stage[c] * 256 + wd;
                if (wr && r == 3) m_stage[c] = wd;
                if (wr && r == 4) begin
                    m_en[c] = wd[0]; m_os[c] = wd[1] && OS_OK; m_ie[c] = wd[2];
                end
                m_ovr[c]  = (evt && pend0) || (m_ovr[c] && !(wr && r == 5 && wd[1]));
                m_pend[c] = evt || (pend0 && !(wr && r == 5 && wd[0]));
                if (evt && ie0) irq_set = 1'b1;
            end
            if (irq_set) m_irq = 1'b1;
            else if (bus_if.irq_ack) m_irq = 1'b0;
        end
    end

    // Monitor: RAISE every cycle, and one scoreboard pop per driven read cycle.
    always @(negedge clk) begin
        sb_t e;
        if (mon_on && rst_n) begin
            tests++;
            if (bus_if.irq_raise !== m_irq) begin
                fails++;
                $display("FAIL irq_raise t=%0t got=%b expected=%b", $time, bus_if.irq_raise, m_irq);
            end
            if (m_out_valid) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL read_queue_empty t=%0t got=%h expected=<entry>", $time, bus_data);
                end else begin
                    e = sb_q.pop_front();
                    if (bus_data !== e.exp) begin
                        fails++;
                        $display("FAIL read addr=%h t=%0t got=%h expected=%h", e.addr, $time, bus_data, e.exp);
                    end else begin
                        $display("[TB] rd addr=%h data=%h ok", e.addr, bus_data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic set_in(input logic [7:0] a, input logic we, input logic [7:0] d, input logic ack);
        bus_if.bus_addr = a;
        bus_if.bus_we   = we;
        tb_wdata        = d;
        tb_drv          = we;
        bus_if.irq_ack  = ack;
    endtask

    task automatic step(input logic [7:0] a, input logic we, input logic [7:0] d, input logic ack);
        @(negedge clk);
        set_in(a, we, d, ack);
    endtask

    task automatic idle(input int n);
        repeat (n) step(8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(a, 1'b1, d, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(a, 1'b0, 8'h00, 1'b0);
    endtask

    // Returns at a negedge whose cycle has ch c's event pending; caller sets that cycle's inputs.
    task automatic wait_event_cycle(input string name, input int c, input int lim);
        int n;
        n = 0;
        @(negedge clk);
        while (!ev_now(c) && n < lim) begin
            set_in(8'h00, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
            n++;
        end
        check(name, 32'(ev_now(c)), 32'd1);
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        set_in(8'h00, 1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1 check(name, 32'(bus_if.irq_raise), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit last_rd;
        logic [7:0] a, d;
        logic we, ack;

        set_in(8'h00, 1'b0, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_raise", 32'(bus_if.irq_raise), 32'd0);
        mon_on = 1'b1;
        rst_n  = 1'b1;

        // Default ch0: 100th tick lands on edge 400 after release
        n = 0;
        while (bus_if.irq_raise !== 1'b1 && n < 500) begin
            @(posedge clk);
            #1 n++;
        end
        check("first_event_edge", 32'(n), 32'd400);
        step(8'h00, 1'b0, 8'h00, 1'b1);
        rd(8'hE5);
        idle(1);
        wr(8'hE5, 8'h01);
        idle(1);

        // Ch1 one-shot, period 3
        wr(8'hEB, 8'h00);
        wr(8'hEA, 8'h03);
        wr(8'hEC, 8'h03);
        idle(100);
        rd(8'hEC);
        rd(8'hE8);
        rd(8'hED);
        idle(1);

        // Ch0 period 2, PEND left set across several events, then W1C
        wr(8'hE4, 8'h05);
        wr(8'hE3, 8'h00);
        wr(8'hE2, 8'h02);
        wr(8'hE5, 8'h03);
        idle(26);
        rd(8'hE5);
        idle(1);
        wr(8'hE5, 8'h03);
        rd(8'hE5);
        idle(1);
        step(8'h00, 1'b0, 8'h00, 1'b1);
        idle(1);

        // Free-running ch1, split 16-bit read across a tick at 16'h01FF
        pulse_reset("reset_raise_async_d");
        idle(1);
        wr(8'hEB, 8'h00);
        wr(8'hEA, 8'h00);
        wr(8'hEC, 8'h01);
        n = 0;
        @(negedge clk);
        while (!(m_cnt[1] == 16'h01FF && m_ps == PS - 1) && n < 3000) begin
            set_in(8'h00, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
            n++;
        end
        check("reach_cnt_01ff", 32'(m_cnt[1]), 32'h01FF);
        set_in(8'hE8, 1'b0, 8'h00, 1'b0);
        rd(8'hE9);
        idle(2);

        // ACK coinciding with a ch0 event
        wait_event_cycle("wait_ev_ack", 0, 1000);
        set_in(8'h00, 1'b0, 8'h00, 1'b1);
        idle(1);
        check("ack_vs_event_raise", 32'(bus_if.irq_raise), 32'd1);

        // CLEAR on an event tick (with ACK): no event, counter zero
        wait_event_cycle("wait_ev_clear", 0, 1000);
        set_in(8'hE6, 1'b1, 8'h00, 1'b1);
        rd(8'hE0);
        check("clear_vs_tick_raise", 32'(bus_if.irq_raise), 32'd0);
        idle(1);
        rd(8'hE5);
        idle(2);

        // Randomised bus traffic
        last_rd = 1'b0;
        for (int i = 0; i < 400; i++) begin
            a = 8'(BASE + $urandom_range(0, 8 * NCH - 1));
            if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(0, 255));
            we  = !last_rd && ($urandom_range(0, 2) == 0);
            d   = 8'($urandom_range(0, 255));
            if (a[2:0] == 3'd2) d = 8'($urandom_range(0, 6));
            if (a[2:0] == 3'd3) d = 8'($urandom_range(0, 1));
            ack = ($urandom_range(0, 7) == 0);
            step(a, we, d, ack);
            last_rd = !we && in_win(a);
        end
        idle(2);

        // Reset while RAISE is high, then read every register back
        wr(8'hE4, 8'h05);
        wr(8'hE3, 8'h00);
        wr(8'hE2, 8'h05);
        n = 0;
        @(negedge clk);
        while (!m_irq && n < 200) begin
            set_in(8'h00, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
            n++;
        end
        check("raise_before_reset", 32'(bus_if.irq_raise), 32'd1);
        pulse_reset("reset_raise_async");
        for (int k = 0; k < 8 * NCH; k++) rd(8'(BASE + k));
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
